activation_unit: RTL and testbench

- Downstream consumer of systolic-array results and upstream producer of the controller's `activations`/`activation_ready`/`activated` inputs.
- Each accepted 64-bit result row is treated as 8 signed int8 lanes:
  - per-lane bias add;
  - selectable activation function;
  - saturation back to int8;
  - buffering in a small FIFO until the controller pops it for the output SRAM region.
- Counts rows against `num_input` and pulses `activated` once the whole batch has drained.

---
 rtl/act_pkg.sv | 33 +++
 rtl/act_fifo.sv | 59 +++++
 rtl/activation_unit.sv | 140 ++++++++++++++
 tb/tb_activation_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared types, constants and the int8 saturation helper for the activation unit.
package act_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RELU2 = 2'b11
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } act_state_t;

  // Clamp a LANE_W+1 bit signed sum to LANE_W bits. The two top bits disagree
  // exactly when the value is outside the narrow range; bit LANE_W gives the sign.
  function automatic logic [LANE_W-1:0] sat_int8(input logic [LANE_W:0] v);
    if (!v[LANE_W] && v[LANE_W-1]) begin
      return {1'b0, {(LANE_W-1){1'b1}}};
    end else if (v[LANE_W] && !v[LANE_W-1]) begin
      return {1'b1, {(LANE_W-1){1'b0}}};
    end else begin
      return v[LANE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/act_fifo.sv
// Synchronous FIFO with flush; a push is accepted when full if a pop happens in the same cycle.
module act_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Head is forced to zero when empty so the output never shows stale or unknown storage.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Row storage.
  // NOTE: storage has no reset; occupancy alone decides validity, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/activation_unit.sv
// Bias add, activation and int8 saturation on systolic-array result rows, buffered for the controller.
module activation_unit
  import act_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start_array,
  input  logic [7:0]               num_input,
  input  logic [1:0]               act_mode,
  input  logic                     bias_load,
  input  logic [LANES*LANE_W-1:0]  bias_data,
  input  logic                     array_valid,
  input  logic [LANES*LANE_W-1:0]  array_data,
  input  logic                     act_pop,
  output logic [LANES*LANE_W-1:0]  activations,
  output logic                     activation_ready,
  output logic                     activated,
  output logic                     overflow_err,
  output logic                     busy
);

  localparam int unsigned ROW_W = LANES * LANE_W;

  act_state_t       state_q, state_d;
  act_mode_t        mode_q, mode_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       count_q, count_d;
  logic [ROW_W-1:0] bias_q;
  logic [ROW_W-1:0] lane_out;
  logic [ROW_W-1:0] stage_data_q, stage_data_d;
  logic             stage_valid_q, stage_valid_d;
  logic             overflow_q, overflow_d;
  logic             accept;
  logic             flush;
  logic             fifo_full;
  logic             fifo_empty;

  // Per-lane arithmetic on the incoming row, using the latched mode and current bias.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W:0]          sum;
    logic signed [LANE_W-1:0] clamped;
    logic [LANE_W-1:0]        res;

    // Sign-extended add, then activation; negative leaky inputs are clamped to int8 before the shift.
    always_comb begin
      sum     = {array_data[LANE_W*i+LANE_W-1], array_data[LANE_W*i +: LANE_W]}
              + {bias_q[LANE_W*i+LANE_W-1], bias_q[LANE_W*i +: LANE_W]};
      clamped = sat_int8(sum);
      case (mode_q)
        ACT_PASS:  res = clamped;
        ACT_LEAKY: res = sum[LANE_W] ? LANE_W'(clamped >>> LEAK_SHIFT) : clamped;
        default:   res = sum[LANE_W] ? '0 : clamped;
      endcase
    end

    assign lane_out[LANE_W*i +: LANE_W] = res;
  end

  // Batch control: start handling, row counting, drain detection and pipe stage loading.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    mode_d        = mode_q;
    num_d         = num_q;
    count_d       = count_q;
    accept        = 1'b0;
    flush         = 1'b0;
    overflow_d    = overflow_q | (stage_valid_q && fifo_full && !act_pop);
    if (start_array) begin
      flush      = 1'b1;
      num_d      = num_input;
      mode_d     = act_mode_t'(act_mode);
      count_d    = '0;
      overflow_d = 1'b0;
      state_d    = (num_input == 8'd0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (array_valid) begin
            accept  = 1'b1;
            count_d = count_q + 8'd1;
            if (count_q + 8'd1 == num_q) state_d = DRAIN;
          end
        end
        DRAIN: if (!stage_valid_q && fifo_empty) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    stage_valid_d = accept;
    stage_data_d  = accept ? lane_out : stage_data_q;
  end

  // Control, bias and pipe stage registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      mode_q        <= ACT_PASS;
      num_q         <= '0;
      count_q       <= '0;
      bias_q        <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      num_q         <= num_d;
      count_q       <= count_d;
      if (bias_load) bias_q <= bias_data;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      overflow_q    <= overflow_d;
    end
  end

  act_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush_i (flush),
    .push_i  (stage_valid_q),
    .pop_i   (act_pop),
    .data_i  (stage_data_q),
    .data_o  (activations),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign activation_ready = !fifo_empty;
  assign activated        = (state_q == DONE);
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit.
module tb_activation_unit;

  logic        clk;
  logic        n_rst;
  logic        start_array;
  logic [7:0]  num_input;
  logic [1:0]  act_mode;
  logic        bias_load;
  logic [63:0] bias_data;
  logic        array_valid;
  logic [63:0] array_data;
  logic        act_pop;
  logic [63:0] activations;
  logic        activation_ready;
  logic        activated;
  logic        overflow_err;
  logic        busy;

  int cmp_cnt = 0;
  int err_cnt = 0;

  activation_unit dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start_array      (start_array),
    .num_input        (num_input),
    .act_mode         (act_mode),
    .bias_load        (bias_load),
    .bias_data        (bias_data),
    .array_valid      (array_valid),
    .array_data       (array_data),
    .act_pop          (act_pop),
    .activations      (activations),
    .activation_ready (activation_ready),
    .activated        (activated),
    .overflow_err     (overflow_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic start_batch(input logic [7:0] n, input logic [1:0] m);
    start_array = 1'b1;
    num_input   = n;
    act_mode    = m;
    step();
    start_array = 1'b0;
  endtask

  task automatic load_bias(input logic [63:0] b);
    bias_load = 1'b1;
    bias_data = b;
    step();
    bias_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; start_array = 1'b0; num_input = '0; act_mode = '0;
    bias_load = 1'b0; bias_data = '0; array_valid = 1'b0; array_data = '0; act_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_activations", activations, 64'h0);
    check("rst_ready", 64'(activation_ready), 64'h0);
    check("rst_activated", 64'(activated), 64'h0);
    check("rst_overflow", 64'(overflow_err), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    step();

    // ReLU with +1 bias on every lane.
    load_bias(rep(8'h01));
    start_batch(8'd2, 2'b01);
    check("relu_busy", 64'(busy), 64'h1);
    array_valid = 1'b1; array_data = 64'h7F80_00FF_0102_FE05;
    step();
    check("relu_ready_n1", 64'(activation_ready), 64'h0);
    array_data = 64'h0;
    step();
    array_valid = 1'b0;
    check("relu_ready_n2", 64'(activation_ready), 64'h1);
    check("relu_row0", activations, 64'h7F00_0100_0203_0006);
    act_pop = 1'b1;
    step();
    check("relu_row1", activations, 64'h0101_0101_0101_0101);
    step();
    act_pop = 1'b0;
    check("relu_empty", 64'(activation_ready), 64'h0);
    check("relu_no_early_act", 64'(activated), 64'h0);
    check("relu_drain_busy", 64'(busy), 64'h1);
    step();
    check("relu_activated", 64'(activated), 64'h1);
    check("relu_done_busy", 64'(busy), 64'h0);
    step();
    check("relu_activated_off", 64'(activated), 64'h0);

    // Leaky ReLU; the bias change issued with row 0 applies to row 1 only.
    load_bias(64'h0);
    start_batch(8'd2, 2'b10);
    array_valid = 1'b1; array_data = 64'h0000_0000_00F0_05C0;
    bias_load = 1'b1; bias_data = 64'h0000_0000_0000_00FF;
    step();
    bias_load = 1'b0;
    array_data = 64'h0000_0000_0000_0080;
    step();
    array_valid = 1'b0;
    check("leaky_row0", activations, 64'h0000_0000_00FE_05F8);
    act_pop = 1'b1;
    step();
    check("leaky_row1_sat", activations, 64'h0000_0000_0000_00F0);
    step();
    act_pop = 1'b0;
    check("leaky_empty", 64'(activation_ready), 64'h0);
    step();
    check("leaky_activated", 64'(activated), 64'h1);
    step();

    // Overflow: six back-to-back rows into a four-deep buffer, no pops.
    load_bias(64'h0);
    start_batch(8'd6, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      array_valid = 1'b1; array_data = rep(8'h10 + 8'(k));
      step();
    end
    array_valid = 1'b0;
    check("ovf_set_row5", 64'(overflow_err), 64'h1);
    step();
    check("ovf_sticky", 64'(overflow_err), 64'h1);
    check("ovf_ready", 64'(activation_ready), 64'h1);
    check("ovf_drain_busy", 64'(busy), 64'h1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_pop%0d", k), activations, rep(8'h10 + 8'(k)));
      act_pop = 1'b1;
      step();
    end
    act_pop = 1'b0;
    check("ovf_empty", 64'(activation_ready), 64'h0);
    check("ovf_no_early_act", 64'(activated), 64'h0);
    step();
    check("ovf_activated", 64'(activated), 64'h1);
    check("ovf_still_set", 64'(overflow_err), 64'h1);
    step();
    check("ovf_activated_off", 64'(activated), 64'h0);

    // Zero-row batch: immediate completion pulse, also clears the overflow flag.
    start_batch(8'd0, 2'b00);
    check("zero_ovf_clear", 64'(overflow_err), 64'h0);
    check("zero_activated", 64'(activated), 64'h1);
    check("zero_busy", 64'(busy), 64'h0);
    step();
    check("zero_activated_off", 64'(activated), 64'h0);
    check("zero_busy_idle", 64'(busy), 64'h0);
    array_valid = 1'b1; array_data = rep(8'h55);
    step();
    array_valid = 1'b0;
    step();
    step();
    check("idle_ignore_ready", 64'(activation_ready), 64'h0);
    check("idle_ignore_data", activations, 64'h0);

    // Push and pop together while full for ten cycles, then drain.
    start_batch(8'd14, 2'b00);
    for (int c = 0; c <= 18; c++) begin
      array_valid = (c < 14);
      array_data  = rep(8'h20 + 8'(c));
      act_pop     = (c >= 5);
      if (c >= 5) begin
        check($sformatf("full_rdy%0d", c), 64'(activation_ready), 64'h1);
        check($sformatf("full_head%0d", c), activations, rep(8'h20 + 8'(c - 5)));
      end
      step();
    end
    array_valid = 1'b0; act_pop = 1'b0;
    check("full_no_ovf", 64'(overflow_err), 64'h0);
    check("full_empty", 64'(activation_ready), 64'h0);
    check("full_no_early_act", 64'(activated), 64'h0);
    step();
    check("full_activated", 64'(activated), 64'h1);
    step();

    // Asynchronous reset in RUN with two rows buffered.
    start_batch(8'd5, 2'b00);
    for (int k = 0; k < 3; k++) begin
      array_valid = 1'b1; array_data = rep(8'h40 + 8'(k));
      step();
    end
    array_valid = 1'b0;
    check("mid_ready", 64'(activation_ready), 64'h1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_activations", activations, 64'h0);
    check("mid_rst_ready", 64'(activation_ready), 64'h0);
    check("mid_rst_activated", 64'(activated), 64'h0);
    check("mid_rst_overflow", 64'(overflow_err), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_ready", 64'(activation_ready), 64'h0);
    check("post_rst_activated", 64'(activated), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
